// File: rtl/uart_pkg.sv
// Shared UART package: tx state encoding, tx datapath control points, baud divisor helper.
// UART_TX_PARITY_EN adds the PARITY state to the tx state encoding.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        , TX_PARITY = 3'd4
`endif
    } tx_state_e;

    // What the registered tx pin takes on the next edge.
    typedef enum logic [1:0] {
        TX_SEL_ONE  = 2'd0,
        TX_SEL_ZERO = 2'd1,
        TX_SEL_BIT  = 2'd2,
        TX_SEL_PAR  = 2'd3
    } tx_sel_e;

    typedef struct packed {
        logic en;
        logic clr;
    } cnt_ctrl_t;

    typedef struct packed {
        logic load;
        logic shift;
    } shift_ctrl_t;

    typedef struct packed {
        cnt_ctrl_t   baud_ctrl;
        cnt_ctrl_t   bit_ctrl;
        shift_ctrl_t shift_ctrl;
        tx_sel_e     tx_sel;
    } tx_ctrl_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_datapath.sv
// UART tx datapath: baud counter, data bit counter, shift register and registered tx pin.
// UART_TX_PARITY_EN adds the captured even-parity bit and its output flag.
module uart_tx_datapath
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  tx_ctrl_t              ctrl,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  bit_end,
    output logic                  last_bit,
`ifdef UART_TX_PARITY_EN
    output logic                  parity,
`endif
    output logic                  tx
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int NW = $clog2(DATA_WIDTH);

    logic [BW-1:0]         baud_q, baud_d;
    logic [NW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic                  par_q, par_d;
`endif

    assign bit_end  = (baud_q == BW'(CLKS_PER_BIT - 1));
    assign last_bit = (bit_q == NW'(DATA_WIDTH - 1));
    assign tx       = tx_q;

    always_comb begin
        baud_d = baud_q;
        if (ctrl.baud_ctrl.clr)     baud_d = '0;
        else if (ctrl.baud_ctrl.en) baud_d = baud_q + BW'(1);

        bit_d = bit_q;
        if (ctrl.bit_ctrl.clr)      bit_d = '0;
        else if (ctrl.bit_ctrl.en)  bit_d = bit_q + NW'(1);

        shreg_d = shreg_q;
        if (ctrl.shift_ctrl.load)       shreg_d = tx_data;
        else if (ctrl.shift_ctrl.shift) shreg_d = shreg_q >> 1;

`ifdef UART_TX_PARITY_EN
        par_d = ctrl.shift_ctrl.load ? ^tx_data : par_q;
`endif

        // tx is registered, so it follows the post-edge state and shift register.
        case (ctrl.tx_sel)
            TX_SEL_ZERO: tx_d = 1'b0;
            TX_SEL_BIT:  tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            TX_SEL_PAR:  tx_d = par_q;
`endif
            default:     tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

`ifdef UART_TX_PARITY_EN
    assign parity = par_q;
`endif

endmodule

// File: rtl/uart_tx.sv
// UART transmitter top: frame FSM and valid/ready handshake over uart_tx_datapath.
// UART_TX_PARITY_EN inserts an even-parity bit between the last data bit and the stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx,
    output logic                  busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx: CLKS_PER_BIT must be at least 2");
    end
    if (DATA_WIDTH < 2) begin : g_bad_dw
        $error("uart_tx: DATA_WIDTH must be at least 2");
    end

    localparam logic [2:0] S_IDLE   = 3'(TX_IDLE);
    localparam logic [2:0] S_START  = 3'(TX_START);
    localparam logic [2:0] S_DATA   = 3'(TX_DATA);
    localparam logic [2:0] S_STOP   = 3'(TX_STOP);
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'(TX_PARITY);
`endif

    logic [2:0] state_q, state_d;
    logic       bit_end, last_bit, accept;
    tx_ctrl_t   ctrl;

    // Ready on the last stop cycle lets the next start bit follow with no gap.
    assign tx_ready = (state_q == S_IDLE) || (state_q == S_STOP && bit_end);
    assign accept   = tx_valid && tx_ready;
    assign busy     = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_START;
            S_START: if (bit_end) state_d = S_DATA;
            S_DATA:
                if (bit_end && last_bit) begin
`ifdef UART_TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (bit_end) state_d = S_STOP;
`endif
            S_STOP:  if (bit_end) state_d = accept ? S_START : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ctrl                  = '0;
        ctrl.baud_ctrl.en     = 1'b1;
        ctrl.baud_ctrl.clr    = (state_q == S_IDLE) || bit_end;
        ctrl.bit_ctrl.en      = (state_q == S_DATA) && bit_end && !last_bit;
        ctrl.bit_ctrl.clr     = (state_q != S_DATA);
        ctrl.shift_ctrl.load  = accept;
        ctrl.shift_ctrl.shift = (state_q == S_DATA) && bit_end;
        case (state_d)
            S_START:  ctrl.tx_sel = TX_SEL_ZERO;
            S_DATA:   ctrl.tx_sel = TX_SEL_BIT;
`ifdef UART_TX_PARITY_EN
            S_PARITY: ctrl.tx_sel = TX_SEL_PAR;
`endif
            default:  ctrl.tx_sel = TX_SEL_ONE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    uart_tx_datapath #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_datapath (
        .clock    (clock),
        .reset    (reset),
        .ctrl     (ctrl),
        .tx_data  (tx_data),
        .bit_end  (bit_end),
        .last_bit (last_bit),
`ifdef UART_TX_PARITY_EN
        .parity   (),
`endif
        .tx       (tx)
    );

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at 10 clocks per bit; follows UART_TX_PARITY_EN if defined.
module tb_uart_tx;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int DW       = 8;
    localparam int CPB      = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NB = DW + 3;
`else
    localparam int NB = DW + 2;
`endif
    localparam int FLEN = NB * CPB;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          tx_valid = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_ready, tx, busy;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    uart_tx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD),
        .DATA_WIDTH (DW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .busy     (busy)
    );

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;  // start, data LSB first, stop; bit 0 goes out first
        logic       par;
        bit         b2b;    // next entry is accepted on this frame's last stop cycle
    } vec_t;

    vec_t tab [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference frame built straight from the frame definition.
    function automatic logic [NB-1:0] model_frame(input logic [DW-1:0] w);
        logic [NB-1:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < DW; i++) f[i+1] = w[i];
`ifdef UART_TX_PARITY_EN
        f[DW+1] = ^w;
`endif
        return f;
    endfunction

    function automatic logic [NB-1:0] tab_frame(input vec_t v);
`ifdef UART_TX_PARITY_EN
        return {1'b1, v.par, v.frame[8:0]};
`else
        return v.frame;
`endif
    endfunction

    task automatic check_idle(input string name);
        chk(name, {29'd0, tx, tx_ready, busy}, 32'b110);
    endtask

    // Called at a negedge; leaves us at the negedge of cycle 1 after the accept edge.
    task automatic accept_word(input logic [DW-1:0] w);
        int n = 0;
        while (!tx_ready && n < 1000) begin
            @(negedge clock);
            n++;
        end
        chk("accept_ready", {31'd0, tx_ready}, 32'd1);
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clock);
    endtask

    // Walks cycles 1..FLEN of a frame; optionally offers the next word on the last stop cycle.
    task automatic check_frame(input logic [NB-1:0] f, input bit has_next,
                               input logic [DW-1:0] nxt, input bit noise);
        for (int k = 1; k <= FLEN; k++) begin
            chk($sformatf("tx_bit cyc=%0d", k), {31'd0, tx}, {31'd0, f[(k-1)/CPB]});
            chk($sformatf("busy cyc=%0d", k), {31'd0, busy}, 32'd1);
            chk($sformatf("ready cyc=%0d", k), {31'd0, tx_ready}, {31'd0, k == FLEN});
            if (k == FLEN) begin
                tx_valid = has_next;
                tx_data  = nxt;
            end else if (noise) begin
                tx_data  = DW'($urandom);
                tx_valid = 1'($urandom);
            end else begin
                tx_valid = 1'b0;
            end
            @(negedge clock);
        end
    endtask

    initial begin
        logic [DW-1:0] w, nxt;
        logic [NB-1:0] mf;
        bit            prev_b2b, hn;

        tab[0] = '{8'hA5, 10'h34A, 1'b0, 1'b0};
        tab[1] = '{8'h00, 10'h200, 1'b0, 1'b1};
        tab[2] = '{8'hFF, 10'h3FE, 1'b0, 1'b0};
        tab[3] = '{8'h07, 10'h20E, 1'b1, 1'b0};
        tab[4] = '{8'h03, 10'h206, 1'b0, 1'b0};
        tab[5] = '{8'h01, 10'h202, 1'b1, 1'b1};
        tab[6] = '{8'h81, 10'h302, 1'b0, 1'b0};

        // Reset, then a long idle with no requests.
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_idle("reset_state");
        reset = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            check_idle("idle_hold");
        end

        // Directed table, including one gapless pair of frames.
        prev_b2b = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (!prev_b2b) accept_word(tab[i].data);
            nxt = (i < 6) ? tab[i+1].data : '0;
            check_frame(tab_frame(tab[i]), tab[i].b2b, nxt, 1'b0);
            if (!tab[i].b2b) check_idle("table_frame_end");
            prev_b2b = tab[i].b2b;
        end

        // Reset and accept in the same cycle: reset wins.
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        reset    = 1'b1;
        @(negedge clock);
        check_idle("reset_beats_accept");
        reset    = 1'b0;
        tx_valid = 1'b0;
        @(negedge clock);
        check_idle("reset_beats_accept_after");

        // Reset during cycle 45 of a 0x55 frame, then a clean 0x3C.
        accept_word(8'h55);
        mf = model_frame(8'h55);
        for (int k = 1; k < 45; k++) begin
            tx_valid = 1'b0;
            chk("pre_reset_bit", {31'd0, tx}, {31'd0, mf[(k-1)/CPB]});
            @(negedge clock);
        end
        reset = 1'b1;
        @(negedge clock);
        check_idle("mid_frame_reset");
        reset = 1'b0;
        @(negedge clock);
        check_idle("after_mid_reset");
        accept_word(8'h3C);
        check_frame(model_frame(8'h3C), 1'b0, '0, 1'b0);
        check_idle("post_reset_frame_end");

        // Input noise while busy must not disturb the frame or start another.
        accept_word(8'hC3);
        check_frame(model_frame(8'hC3), 1'b0, '0, 1'b1);
        for (int i = 0; i < 3 * CPB; i++) begin
            check_idle("no_extra_frame");
            @(negedge clock);
        end

        // Random words, gaps and back-to-back chaining.
        w = DW'($urandom);
        accept_word(w);
        for (int i = 0; i < 16; i++) begin
            nxt = DW'($urandom);
            hn  = (i < 15) && ($urandom_range(0, 1) == 1);
            check_frame(model_frame(w), hn, nxt, (i % 3) == 0);
            if (!hn) begin
                check_idle("rand_frame_end");
                repeat ($urandom_range(0, 5)) @(negedge clock);
                if (i < 15) accept_word(nxt);
            end
            w = nxt;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
